// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction queue, circular buffer with first-word-fall-through head
// Optional same-cycle empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int              SIZE      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [SIZE-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [SIZE-1:0]            pc_in,
    input  logic [SIZE-1:0]            instr_in,
    input  logic                       id_stall,
    output logic                       full,
    output logic                       valid_out,
    output logic [SIZE-1:0]            pc_out,
    output logic [SIZE-1:0]            instr_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SIZE-1:0] r_mem_pc    [DEPTH];
    logic [SIZE-1:0] r_mem_instr [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic w_empty;
    logic w_bypass;
    logic w_pop;
    logic w_push_acc;
    logic w_wr_en;
    logic w_rd_en;

    assign w_empty   = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count_out = r_count;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && push && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        valid_out = !w_empty;
        pc_out    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
        instr_out = w_empty ? NOP_INSTR : r_mem_instr[r_rd_ptr];
        if (w_bypass) begin
            valid_out = 1'b1;
            pc_out    = pc_in;
            instr_out = instr_in;
        end
    end

    // A pop frees a slot on the same edge, so a full queue can still take a push.
    assign w_pop      = valid_out && !id_stall;
    assign w_push_acc = push && (!full || w_pop);
    // A bypassed entry consumed by decode never touches storage.
    assign w_wr_en    = w_push_acc && !(w_bypass && w_pop);
    assign w_rd_en    = w_pop && !w_bypass;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr_en) begin
            r_mem_pc[r_wr_ptr]    <= pc_in;
            r_mem_instr[r_wr_ptr] <= instr_in;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue (either FETCH_QUEUE_BYPASS_EN build)
module tb_fetch_queue;

    localparam int SIZE  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, flush, push, id_stall;
    logic [31:0] pc_in, instr_in;
    logic        full, valid_out;
    logic [31:0] pc_out, instr_out;
    logic [2:0]  count_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_pc [$];

    fetch_queue #(.SIZE(SIZE), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push(push),
        .pc_in(pc_in), .instr_in(instr_in), .id_stall(id_stall),
        .full(full), .valid_out(valid_out), .pc_out(pc_out),
        .instr_out(instr_out), .count_out(count_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h00B3} ^ 32'h5A000000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic p, input logic [31:0] pc, input logic st, input logic fl);
        push     = p;
        pc_in    = pc;
        instr_in = instr_of(pc);
        id_stall = st;
        flush    = fl;
    endtask

    // Samples at the falling edge, compares against the scoreboard, updates it, then crosses the rising edge.
    task automatic cycle();
        logic        exp_valid, pop, acc, byp;
        logic [31:0] exp_pc;
        @(negedge clk);
        if (rst) begin
            sb_pc.delete();
        end else begin
            byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (sb_pc.size() == 0) && push && !flush;
`endif
            exp_valid = (sb_pc.size() != 0) || byp;
            check("valid_out", valid_out, exp_valid);
            check("count_out", count_out, sb_pc.size());
            check("full", full, sb_pc.size() == DEPTH);
            if (exp_valid) begin
                exp_pc = byp ? pc_in : sb_pc[0];
                check("pc_out", pc_out, exp_pc);
                check("instr_out", instr_out, instr_of(exp_pc));
            end else begin
                check("pc_out_empty", pc_out, 0);
                check("instr_out_nop", instr_out, NOP);
            end
            pop = exp_valid && !id_stall;
            acc = push && ((sb_pc.size() < DEPTH) || pop);
            if (flush) begin
                sb_pc.delete();
            end else if (!(byp && pop)) begin
                if (pop) void'(sb_pc.pop_front());
                if (acc) sb_pc.push_back(pc_in);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        drive(0, 0, 0, 0);
        while (sb_pc.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        check("drain_done", sb_pc.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_valid", valid_out, 0);
        check("rst_instr", instr_out, NOP);
        check("rst_pc", pc_out, 0);
        check("rst_count", count_out, 0);
        check("rst_full", full, 0);
        cycle();

        // Fill while decode stalls, then offer one more which must be dropped.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i * 4), 1, 0);
            cycle();
        end
        drive(0, 0, 1, 0);
        check("fill_full", full, 1);
        check("fill_count", count_out, 4);
        drive(1, 32'h10, 1, 0);
        cycle();
        check("drop_count", count_out, 4);
        check("drop_head", pc_out, 32'h0);

        // Full with push and pop together.
        drive(1, 32'h10, 0, 0);
        cycle();
        check("pp_count", count_out, 4);
        check("pp_head", pc_out, 32'h4);
        drain();

        // Flush with a coincident push.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h100 + 32'(i * 4), 1, 0);
            cycle();
        end
        drive(1, 32'h20, 0, 1);
        cycle();
        drive(0, 0, 0, 0);
        check("flush_count", count_out, 0);
        check("flush_valid", valid_out, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Pointer wrap: prime two entries, then push and pop every cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h200 + 32'(i * 4), (i < 2), 0);
            cycle();
        end
        drain();

        // Empty-queue push, decode ready.
        drive(1, 32'h40, 0, 0);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_valid_same", valid_out, 1);
        check("byp_pc_same", pc_out, 32'h40);
`else
        check("nobyp_valid_same", valid_out, 0);
`endif
        cycle();
        drive(0, 0, 0, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_count_after", count_out, 0);
`else
        check("nobyp_valid_next", valid_out, 1);
        check("nobyp_pc_next", pc_out, 32'h40);
`endif
        drain();

        // Reset in the middle of operation.
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h300 + 32'(i * 4), 1, 0);
            cycle();
        end
        rst = 1'b1;
        drive(1, 32'h308, 0, 0);
        cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        check("midrst_count", count_out, 0);
        check("midrst_valid", valid_out, 0);
        check("midrst_instr", instr_out, NOP);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, meaning PC and instruction width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of queue entries; legal values are powers of two, 2 to 16.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the instruction presented when the queue is empty (addi x0,x0,0).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port flush, input, 1 bit: discard all queued and incoming entries (taken branch or jump).
REQ-007 The block SHALL have port push, input, 1 bit: fetch stage offers pc_in/instr_in this cycle.
REQ-008 The block SHALL have port pc_in, input, SIZE bits: PC of the offered instruction, driven from the PC register output.
REQ-009 The block SHALL have port instr_in, input, SIZE bits: offered instruction word.
REQ-010 The block SHALL have port id_stall, input, 1 bit: decode cannot consume the head entry this cycle.
REQ-011 The block SHALL have port full, output, 1 bit: queue cannot accept; drives the PC register stall input.
REQ-012 The block SHALL have port valid_out, output, 1 bit: pc_out/instr_out hold a real instruction.
REQ-013 The block SHALL have port pc_out, output, SIZE bits: PC of head entry.
REQ-014 The block SHALL have port instr_out, output, SIZE bits: head instruction.
REQ-015 The block SHALL have port count_out, output, log2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-016 The block SHALL hold entries in a circular buffer with registered read pointer, write pointer and count; pointers wrap modulo DEPTH.
REQ-017 The block SHALL drive full = (count == DEPTH), decoded from the registered count only, with no combinational path from push, pop or flush.
REQ-018 The block SHALL define pop = valid_out && !id_stall and remove the head entry on that edge.
REQ-019 The block SHALL accept a push when push && (!full || pop); a push offered while full without a pop SHALL be dropped, with state unchanged.
REQ-020 The block SHALL, on simultaneous accepted push and pop, advance both pointers and leave count unchanged, including at count DEPTH and at count 1.
REQ-021 The block SHALL present the head entry first-word-fall-through: an entry pushed into an empty queue appears on valid_out/pc_out/instr_out one cycle later.
REQ-022 The block SHALL, when empty, drive valid_out=0, pc_out=0 and instr_out=NOP_INSTR.
REQ-023 The block SHALL, on flush, reset the pointers and count to 0 on that edge and discard any push in the same cycle; flush has priority over push and pop.
REQ-024 The block SHALL keep FIFO order; no entry is duplicated, reordered or lost except by flush or reset.

Reset
REQ-025 The block SHALL, on rst high at a rising clk edge, clear the pointers and count, giving full=0, valid_out=0, pc_out=0, instr_out=NOP_INSTR and count_out=0.
REQ-026 The block SHALL give rst priority over flush, push and pop; reset asserted mid-operation discards all entries.
REQ-027 The block SHALL not require the entry storage to be reset.

Configuration
REQ-028 The block SHALL recognise the macro FETCH_QUEUE_BYPASS_EN.
REQ-029 With FETCH_QUEUE_BYPASS_EN defined, when count==0 and push && !flush, the block SHALL drive valid_out=1 and pc_out/instr_out from pc_in/instr_in combinationally in the same cycle.
REQ-030 With FETCH_QUEUE_BYPASS_EN defined, if !id_stall during that bypass cycle the entry SHALL be consumed without being written; if id_stall it SHALL be written and count becomes 1.
REQ-031 Without FETCH_QUEUE_BYPASS_EN, the block SHALL give a minimum push-to-output latency of one cycle, and no combinational path SHALL exist from push, pc_in or instr_in to any output.

Verification
REQ-032 Reset and idle: hold rst for 2 cycles, then idle -> valid_out=0, instr_out=32'h00000013, count_out=0, full=0.
REQ-033 Fill and stall: push PCs 0x0,0x4,0x8,0xC with id_stall=1 -> full=1 after the 4th edge; a 5th push of 0x10 is dropped; releasing id_stall yields 0x0,0x4,0x8,0xC in order.
REQ-034 Full with simultaneous push and pop: while full, push 0x10 with id_stall=0 -> count stays 4, head becomes 0x4, and 0x10 appears last.
REQ-035 Flush with push: queue holds 3 entries, assert flush and push 0x20 together -> next cycle count_out=0, valid_out=0, and 0x20 is never output.
REQ-036 Pointer wrap: stream 10 pushes with pops interleaved at count 2 -> outputs match input order across the wrap.
REQ-037 Bypass: push 0x40 into an empty queue with id_stall=0 -> with FETCH_QUEUE_BYPASS_EN defined, valid_out=1 and pc_out=0x40 in the same cycle with count staying 0; without the macro, 0x40 appears the next cycle.
